// File: rtl/case_conv_pkg.sv
// Shared ASCII case-conversion constants, buffer occupancy states and helpers.
package case_conv_pkg;

  localparam logic [7:0] ASCII_UPPER_A     = 8'd65;
  localparam logic [7:0] ASCII_UPPER_Z     = 8'd90;
  localparam logic [7:0] ASCII_CASE_OFFSET = 8'd32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_t;

  function automatic logic is_upper(input logic [7:0] b);
    return (b >= ASCII_UPPER_A) && (b <= ASCII_UPPER_Z);
  endfunction

  function automatic logic [7:0] to_lower(input logic [7:0] b);
    return is_upper(b) ? (b + ASCII_CASE_OFFSET) : b;
  endfunction

endpackage

// File: rtl/char_fifo2.sv
// Two-entry byte FIFO with registered head output and occupancy FSM.
// in_ready and out_valid are decoded from the state register only.
module char_fifo2
  import case_conv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready
);

  occ_state_t state_q, state_d;
  logic [7:0] head_q, tail_q;
  logic       push, pop;
  logic       load_head_in, load_head_tail, load_tail_in;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = head_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Occupancy state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Next-state and data-path load selects.
  always_comb begin
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_head_tail = 1'b0;
    load_tail_in   = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d      = ONE;
          load_head_in = 1'b1;
        end
      end
      ONE: begin
        if (push && !pop) begin
          state_d      = FULL;
          load_tail_in = 1'b1;
        end else if (!push && pop) begin
          state_d = EMPTY;
        end else if (push && pop) begin
          // Head drains and is replaced by the new byte in the same edge.
          load_head_in = 1'b1;
        end
      end
      FULL: begin
        if (pop) begin
          state_d        = ONE;
          load_head_tail = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Storage registers; head only changes on a load, so it holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (load_head_in)        head_q <= in_data;
      else if (load_head_tail) head_q <= tail_q;
      if (load_tail_in)        tail_q <= in_data;
    end
  end

endmodule

// File: rtl/to_lower_stream.sv
// Streaming ASCII lowercase converter with 2-entry output buffer and
// saturating byte / conversion counters.
module to_lower_stream
  import case_conv_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_char,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_char,
  input  logic             out_ready,
  input  logic             clr_counts,
  output logic [CNT_W-1:0] byte_count,
  output logic [CNT_W-1:0] conv_count
);

  logic             accept;
  logic [7:0]       mapped;
  logic [CNT_W-1:0] byte_base, conv_base;

  assign mapped = to_lower(in_char);
  assign accept = in_valid && in_ready;

  char_fifo2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (mapped),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_char),
    .out_ready (out_ready)
  );

  // Clear takes effect first so a same-cycle accept counts from zero.
  always_comb begin
    byte_base = clr_counts ? '0 : byte_count;
    conv_base = clr_counts ? '0 : conv_count;
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_count <= '0;
      conv_count <= '0;
    end else begin
      byte_count <= byte_base;
      conv_count <= conv_base;
      if (accept && (byte_base != '1))
        byte_count <= byte_base + CNT_W'(1);
      if (accept && is_upper(in_char) && (conv_base != '1))
        conv_count <= conv_base + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_to_lower_stream.sv
// Self-checking bench for to_lower_stream: queue-based reference model,
// directed tables, backpressure, saturation, async reset and full sweep.
module tb_to_lower_stream;

  localparam int unsigned CW  = 4;
  localparam int          MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [7:0]    in_char;
  logic          in_ready;
  logic          out_valid;
  logic [7:0]    out_char;
  logic          out_ready;
  logic          clr_counts;
  logic [CW-1:0] byte_count;
  logic [CW-1:0] conv_count;

  to_lower_stream #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_char    (in_char),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_char   (out_char),
    .out_ready  (out_ready),
    .clr_counts (clr_counts),
    .byte_count (byte_count),
    .conv_count (conv_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: FIFO of mapped bytes (capacity 2) plus counters.
  logic [7:0] q[$];
  int byte_m = 0;
  int conv_m = 0;

  typedef struct {
    logic [7:0] in;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[8];

  function automatic int ref_map(input int c);
    if (c >= 65 && c <= 90) return c + 32;
    return c;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at posedge+1, compare at negedge, update model, advance.
  task automatic step(input logic v, input logic [7:0] c, input logic r, input logic clr);
    bit acc, emit;
    in_valid = v; in_char = c; out_ready = r; clr_counts = clr;
    @(negedge clk);
    check("in_ready", int'(in_ready), int'(q.size() < 2));
    check("out_valid", int'(out_valid), int'(q.size() > 0));
    if (q.size() > 0) check("out_char", int'(out_char), int'(q[0]));
    check("byte_count", int'(byte_count), byte_m);
    check("conv_count", int'(conv_count), conv_m);
    acc  = v && (q.size() < 2);
    emit = r && (q.size() > 0);
    if (emit) void'(q.pop_front());
    if (acc) q.push_back(8'(ref_map(int'(c))));
    if (clr) begin byte_m = 0; conv_m = 0; end
    if (acc) begin
      if (byte_m < MAX) byte_m++;
      if (c >= 8'd65 && c <= 8'd90 && conv_m < MAX) conv_m++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] held;
    tbl[0] = '{8'd65, 8'd97};   tbl[1] = '{8'd90, 8'd122};
    tbl[2] = '{8'd72, 8'd104};  tbl[3] = '{8'd64, 8'd64};
    tbl[4] = '{8'd91, 8'd91};   tbl[5] = '{8'd97, 8'd97};
    tbl[6] = '{8'd122, 8'd122}; tbl[7] = '{8'd183, 8'd183};

    rst = 1'b1; in_valid = 1'b0; in_char = '0; out_ready = 1'b0; clr_counts = 1'b0;
    #2;
    check("rst in_ready", int'(in_ready), 1);
    check("rst out_valid", int'(out_valid), 0);
    check("rst out_char", int'(out_char), 0);
    check("rst byte_count", int'(byte_count), 0);
    check("rst conv_count", int'(conv_count), 0);
    @(posedge clk); #3; rst = 1'b0;
    @(posedge clk); #1;

    // Directed map table, output visible the cycle after each accept.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, tbl[i].in, 1'b1, 1'b0);
      check("map out_valid", int'(out_valid), 1);
      check("map out_char", int'(out_char), int'(tbl[i].exp));
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("map conv_count", int'(conv_count), 3);
    check("map byte_count", int'(byte_count), 8);

    // Backpressure: third byte must wait while FULL.
    step(1'b1, 8'd40, 1'b0, 1'b1);
    step(1'b1, 8'd72, 1'b0, 1'b0);
    check("bp in_ready low", int'(in_ready), 0);
    held = out_char;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'd124, 1'b0, 1'b0);
      check("bp stall stable", int'(out_char), int'(held));
    end
    check("bp head", int'(held), 40);
    step(1'b1, 8'd124, 1'b1, 1'b0);
    check("bp in_ready back", int'(in_ready), 1);
    check("bp second", int'(out_char), 104);
    step(1'b1, 8'd124, 1'b1, 1'b0);
    check("bp third", int'(out_char), 124);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Random push/pop with toggling out_ready.
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0));
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Saturation and clear-with-accept.
    step(1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 8'd65, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("sat byte_count", int'(byte_count), 15);
    check("sat conv_count", int'(conv_count), 15);
    step(1'b1, 8'd66, 1'b1, 1'b1);
    check("clr66 byte_count", int'(byte_count), 1);
    check("clr66 conv_count", int'(conv_count), 1);
    step(1'b1, 8'd48, 1'b1, 1'b1);
    check("clr48 byte_count", int'(byte_count), 1);
    check("clr48 conv_count", int'(conv_count), 0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset while FULL.
    step(1'b1, 8'd65, 1'b0, 1'b0);
    step(1'b1, 8'd66, 1'b0, 1'b0);
    check("pre-rst full", int'(in_ready), 0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst out_valid", int'(out_valid), 0);
    check("arst in_ready", int'(in_ready), 1);
    check("arst byte_count", int'(byte_count), 0);
    check("arst conv_count", int'(conv_count), 0);
    q.delete(); byte_m = 0; conv_m = 0;
    @(posedge clk); #3; rst = 1'b0;
    @(posedge clk); #1;
    step(1'b1, 8'd67, 1'b1, 1'b0);
    check("post-rst out_char", int'(out_char), 99);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Exhaustive sweep: only 65..90 change.
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 8'(i), 1'b1, 1'b0);
      check("sweep changed", int'(out_char != 8'(i)), int'(i >= 65 && i <= 90));
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
